// File: rtl/apb_cmd_sequencer_if.sv
// Signal bundle joining a command host, the sequencer and the downstream APB master.
// The slave modport is the sequencer's view; master is the host/master-side view.
interface apb_cmd_sequencer_if #(
    parameter int DEPTH = 4
) ();
    localparam int LW = $clog2(DEPTH) + 1;

    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_rw;
    logic [8:0]    cmd_addr;
    logic [7:0]    cmd_wdata;
    logic          transfer;
    logic          read_write;
    logic [8:0]    apb_write_paddr;
    logic [7:0]    apb_write_data;
    logic [8:0]    apb_read_paddr;
    logic [7:0]    apb_read_dataout;
    logic          rsp_valid;
    logic [8:0]    rsp_addr;
    logic [7:0]    rsp_rdata;
    logic          busy;
    logic [LW-1:0] level;

    modport slave (
        input  cmd_valid, cmd_rw, cmd_addr, cmd_wdata, apb_read_dataout,
        output cmd_ready, transfer, read_write, apb_write_paddr, apb_write_data,
               apb_read_paddr, rsp_valid, rsp_addr, rsp_rdata, busy, level
    );

    modport master (
        output cmd_valid, cmd_rw, cmd_addr, cmd_wdata, apb_read_dataout,
        input  cmd_ready, transfer, read_write, apb_write_paddr, apb_write_data,
               apb_read_paddr, rsp_valid, rsp_addr, rsp_rdata, busy, level
    );
endinterface

// File: rtl/apb_cmd_sequencer.sv
// Queues host commands in a FIFO and replays each one to an APB master as a fixed-length
// transfer pulse, returning read data as a one-cycle response.
module apb_cmd_sequencer #(
    parameter int DEPTH       = 4,
    parameter int XFER_CYCLES = 2
) (
    input  logic               pclk,
    input  logic               preset,
    apb_cmd_sequencer_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int CW = (XFER_CYCLES > 1) ? $clog2(XFER_CYCLES) : 1;
    localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);
    localparam logic [LW-1:0] LVL_ZERO = LW'(0);
    localparam logic [CW-1:0] CNT_LAST = CW'(XFER_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_XFER = 2'd1,
        S_DONE = 2'd2
    } state_t;

    logic [17:0]   r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [LW-1:0] r_level;
    logic [LW-1:0] w_level_nxt;
    state_t        r_state;
    state_t        w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;
    logic          r_cmd_ready;
    logic          r_busy;
    logic          r_transfer;
    logic          w_transfer_nxt;
    logic          r_read_write;
    logic          w_read_write_nxt;
    logic [8:0]    r_wpaddr;
    logic [8:0]    w_wpaddr_nxt;
    logic [7:0]    r_wdata;
    logic [7:0]    w_wdata_nxt;
    logic [8:0]    r_rpaddr;
    logic [8:0]    w_rpaddr_nxt;
    logic          r_rsp_valid;
    logic          w_rsp_valid_nxt;
    logic [8:0]    r_rsp_addr;
    logic [8:0]    w_rsp_addr_nxt;
    logic [7:0]    r_rsp_rdata;
    logic [7:0]    w_rsp_rdata_nxt;
    logic          w_push;
    logic          w_pop;
    logic          w_last;
    logic [17:0]   w_head;

    // cmd_ready is registered from the level, so a full FIFO never accepts even while popping.
    assign w_push = bus.cmd_valid && r_cmd_ready;
    assign w_pop  = (r_state == S_IDLE) && (r_level != LVL_ZERO);
    assign w_last = (r_cnt == CNT_LAST);
    assign w_head = r_mem[r_rptr];

    // Occupancy update: a simultaneous push and pop leaves the level unchanged.
    always_comb begin
        w_level_nxt = r_level;
        case ({w_push, w_pop})
            2'b10:   w_level_nxt = r_level + LW'(1);
            2'b01:   w_level_nxt = r_level - LW'(1);
            default: w_level_nxt = r_level;
        endcase
    end

    // Command storage; entries need no reset because the pointers define which are valid.
    always_ff @(posedge pclk) begin
        if (w_push) begin
            r_mem[r_wptr] <= {bus.cmd_rw, bus.cmd_addr, bus.cmd_wdata};
        end
    end

    // FIFO pointers, occupancy and the registered ready/busy flags.
    always_ff @(posedge pclk) begin
        if (preset) begin
            r_wptr      <= {AW{1'b0}};
            r_rptr      <= {AW{1'b0}};
            r_level     <= LVL_ZERO;
            r_cmd_ready <= 1'b1;
            r_busy      <= 1'b0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            r_level     <= w_level_nxt;
            r_cmd_ready <= (w_level_nxt != LVL_FULL);
            r_busy      <= (w_state_nxt != S_IDLE) || (w_level_nxt != LVL_ZERO);
        end
    end

    // FSM state register.
    always_ff @(posedge pclk) begin
        if (preset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_pop) begin
                    w_state_nxt = S_XFER;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_XFER: begin
                if (w_last) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_state_nxt = S_XFER;
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // FSM output logic: loads a popped command and captures read data as the pulse ends.
    always_comb begin
        w_transfer_nxt   = r_transfer;
        w_read_write_nxt = r_read_write;
        w_wpaddr_nxt     = r_wpaddr;
        w_wdata_nxt      = r_wdata;
        w_rpaddr_nxt     = r_rpaddr;
        w_rsp_valid_nxt  = 1'b0;
        w_rsp_addr_nxt   = r_rsp_addr;
        w_rsp_rdata_nxt  = r_rsp_rdata;
        w_cnt_nxt        = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_pop) begin
                    w_transfer_nxt   = 1'b1;
                    w_read_write_nxt = w_head[17];
                    w_cnt_nxt        = CW'(0);
                    if (w_head[17]) begin
                        w_rpaddr_nxt = w_head[16:8];
                    end else begin
                        w_wpaddr_nxt = w_head[16:8];
                        w_wdata_nxt  = w_head[7:0];
                    end
                end else begin
                    w_transfer_nxt = 1'b0;
                end
            end
            S_XFER: begin
                if (w_last) begin
                    w_transfer_nxt = 1'b0;
                    if (r_read_write) begin
                        w_rsp_valid_nxt = 1'b1;
                        w_rsp_addr_nxt  = r_rpaddr;
                        w_rsp_rdata_nxt = bus.apb_read_dataout;
                    end else begin
                        w_rsp_valid_nxt = 1'b0;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            S_DONE:  w_transfer_nxt = 1'b0;
            default: w_transfer_nxt = 1'b0;
        endcase
    end

    // Output and counter registers.
    always_ff @(posedge pclk) begin
        if (preset) begin
            r_cnt        <= CW'(0);
            r_transfer   <= 1'b0;
            r_read_write <= 1'b0;
            r_wpaddr     <= 9'd0;
            r_wdata      <= 8'd0;
            r_rpaddr     <= 9'd0;
            r_rsp_valid  <= 1'b0;
            r_rsp_addr   <= 9'd0;
            r_rsp_rdata  <= 8'd0;
        end else begin
            r_cnt        <= w_cnt_nxt;
            r_transfer   <= w_transfer_nxt;
            r_read_write <= w_read_write_nxt;
            r_wpaddr     <= w_wpaddr_nxt;
            r_wdata      <= w_wdata_nxt;
            r_rpaddr     <= w_rpaddr_nxt;
            r_rsp_valid  <= w_rsp_valid_nxt;
            r_rsp_addr   <= w_rsp_addr_nxt;
            r_rsp_rdata  <= w_rsp_rdata_nxt;
        end
    end

    assign bus.cmd_ready       = r_cmd_ready;
    assign bus.transfer        = r_transfer;
    assign bus.read_write      = r_read_write;
    assign bus.apb_write_paddr = r_wpaddr;
    assign bus.apb_write_data  = r_wdata;
    assign bus.apb_read_paddr  = r_rpaddr;
    assign bus.rsp_valid       = r_rsp_valid;
    assign bus.rsp_addr        = r_rsp_addr;
    assign bus.rsp_rdata       = r_rsp_rdata;
    assign bus.busy            = r_busy;
    assign bus.level           = r_level;
endmodule
